riscv_test_checker: RTL and testbench
=====================================

// Module: riscv_test_checker
// PURPOSE
//  Parametrised, synthesizable self-check monitor for the RISC-V multicycle CPU benches and FPGA bring-up.
//  - Holds a loadable table of (instruction count, expected OUTPUT_PORT) pairs.
//  - Checks each pair in order as the core retires instructions.
//  - Counts passes and fails, and reports the first failure.
//  - Ends the run on HALT, on cycle timeout, or on the first fail when STOP_ON_FAIL=1.
//  - Replaces the hard-coded per-bench check loop.
// PARAMETERS
//  NUM_TEST       32      table depth (max checks per run)
//  DWIDTH         32      width of OUTPUT_PORT and expected answer
//  CWIDTH         32      width of NUM_INST, table counts and cycle counter
//  TIMEOUT_CYC    100000  RUN cycles before TIMEOUT is declared
//  STOP_ON_FAIL   0       1: enter DONE on first fail; 0: continue after a fail
// PORTS
//  CLK          in   1                 clock, all logic on posedge
//  RST          in   1                 synchronous reset, active-high
//  TBL_WE       in   1                 table write strobe (accepted in IDLE only)
//  TBL_IDX      in   $clog2(NUM_TEST)  table write index
//  TBL_NINST    in   CWIDTH            instruction count at which to check
//  TBL_ANS      in   DWIDTH            expected OUTPUT_PORT value
//  TBL_LEN      in   $clog2(NUM_TEST)+1  active entry count, latched on START
//  START        in   1                 IDLE->RUN (ignored in other states)
//  NUM_INST     in   CWIDTH            retired-instruction count from core
//  OUTPUT_PORT  in   DWIDTH            core observation port
//  HALT         in   1                 core halt
//  CYCLE        out  CWIDTH            RUN cycle count
//  PASS_CNT     out  $clog2(NUM_TEST)+1  checks passed
//  FAIL_CNT     out  $clog2(NUM_TEST)+1  checks failed (mismatch or missed)
//  FAIL_PULSE   out  1                 1-cycle pulse per failing check
//  FIRST_FAIL   out  $clog2(NUM_TEST)  index of first failing entry
//  FIRST_GOT    out  DWIDTH            OUTPUT_PORT captured at first fail
//  DONE         out  1                 run finished (level, held until RST)
//  TIMEOUT      out  1                 run ended by timeout
//  ALL_PASS     out  1                 DONE & !TIMEOUT & PASS_CNT==latched TBL_LEN
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; ptr=0.
//   - Table contents are NOT cleared; they persist across RST.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE: TBL_WE writes table[TBL_IDX] the same cycle.
//   - IDLE, START=1: latch len=TBL_LEN, go to RUN. If len==0, checks are skipped and RUN waits for HALT/timeout.
//   - RUN: CYCLE += 1 every cycle. TBL_WE is ignored.
//  Ordered check (entries must be ascending in TBL_NINST), ptr<len; e = table[ptr]:
//   - NUM_INST == e.ninst: compare OUTPUT_PORT to e.ans. Equal -> PASS_CNT++; else fail. Then ptr++.
//   - NUM_INST >  e.ninst: missed count -> fail, ptr++. At most one entry is consumed per cycle.
//   - NUM_INST <  e.ninst: no action.
//  On fail:
//   - FAIL_CNT++ and FAIL_PULSE=1 for one cycle.
//   - On the first fail only, capture FIRST_FAIL=ptr and FIRST_GOT=OUTPUT_PORT.
//  Outputs are registered: counters and flags are visible the cycle after the evaluating edge.
//  RUN->DONE, with priority HALT > stop-on-fail > timeout:
//   - HALT=1: the same-cycle check is still evaluated and counted, then DONE; TIMEOUT stays 0.
//   - STOP_ON_FAIL & fail this cycle: DONE.
//   - CYCLE == TIMEOUT_CYC-1 without HALT: DONE, TIMEOUT=1.
//  DONE: all outputs frozen; only RST leaves DONE. START is ignored.
//  Saturation: counters never wrap.
//   - PASS_CNT and FAIL_CNT are bounded by len.
//   - CYCLE saturates at all-ones.
//  Width rules: compares are full-width unsigned equality; NUM_INST is compared unsigned.
//  RST mid-RUN: immediate return to IDLE on the next edge; counters and flags cleared; table kept.
// STRUCTURE
//  Shared header riscv_chk_defs.vh holds:
//   - state encodings (CHK_IDLE=2'd0, CHK_RUN=2'd1, CHK_DONE=2'd2);
//   - the index-width helper macro.
//  One sub-module, riscv_chk_table:
//   - NUM_TEST x (CWIDTH+DWIDTH) register array;
//   - one sync write port and one combinational read port at ptr.
//  FSM, counters and capture logic live in the top.
// TESTING
//  1 All pass: load {(1,5),(2,0),(3,1)}, len=3, drive matching outputs, HALT at NUM_INST=4
//    -> PASS_CNT=3, FAIL_CNT=0, ALL_PASS=1, TIMEOUT=0.
//  2 Mismatch, STOP_ON_FAIL=0: entry1 expects 0x0f, core gives 0x0e
//    -> one FAIL_PULSE, FIRST_FAIL=1, FIRST_GOT=0x0e; run continues; ALL_PASS=0 at HALT.
//  3 Missed count: NUM_INST jumps 1->3 with entry (2,..) pending
//    -> entry2 fails on the first cycle NUM_INST=3; entry3 is evaluated next cycle if NUM_INST is still 3.
//  4 Timeout: TIMEOUT_CYC=50, HALT never asserted
//    -> DONE=1, TIMEOUT=1 after 50 RUN cycles, CYCLE=49, ALL_PASS=0.
//  5 Stop-on-fail plus simultaneity: STOP_ON_FAIL=1, fail on the same cycle as HALT
//    -> FAIL_CNT=1, DONE=1, TIMEOUT=0.
//  6 Reset mid-RUN after 2 passes, then START again without reloading
//    -> counters cleared; table persists; 3 passes are reached again.

Source files
------------

// File: rtl/riscv_test_checker_pkg.sv
// Shared types for the retirement-driven self-check monitor: FSM state encoding
// and the table index-width helper.
package riscv_test_checker_pkg;

    typedef enum logic [1:0] {
        CHK_IDLE = 2'd0,
        CHK_RUN  = 2'd1,
        CHK_DONE = 2'd2
    } chk_state_e;

    // Index width for an n-deep table, never narrower than one bit.
    function automatic int chk_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/riscv_test_checker_if.sv
// Table-load, core-observation and result signals of the test checker, bundled
// so benches and bring-up wrappers connect them in one place.
interface riscv_test_checker_if
    import riscv_test_checker_pkg::*;
#(
    parameter int NUM_TEST = 32,
    parameter int DWIDTH   = 32,
    parameter int CWIDTH   = 32
);
    localparam int IW = chk_idx_w(NUM_TEST);
    localparam int LW = IW + 1;

    logic              TBL_WE;
    logic [IW-1:0]     TBL_IDX;
    logic [CWIDTH-1:0] TBL_NINST;
    logic [DWIDTH-1:0] TBL_ANS;
    logic [LW-1:0]     TBL_LEN;
    logic              START;
    logic [CWIDTH-1:0] NUM_INST;
    logic [DWIDTH-1:0] OUTPUT_PORT;
    logic              HALT;
    logic [CWIDTH-1:0] CYCLE;
    logic [LW-1:0]     PASS_CNT;
    logic [LW-1:0]     FAIL_CNT;
    logic              FAIL_PULSE;
    logic [IW-1:0]     FIRST_FAIL;
    logic [DWIDTH-1:0] FIRST_GOT;
    logic              DONE;
    logic              TIMEOUT;
    logic              ALL_PASS;

    modport master (
        output TBL_WE, TBL_IDX, TBL_NINST, TBL_ANS, TBL_LEN, START,
               NUM_INST, OUTPUT_PORT, HALT,
        input  CYCLE, PASS_CNT, FAIL_CNT, FAIL_PULSE, FIRST_FAIL, FIRST_GOT,
               DONE, TIMEOUT, ALL_PASS
    );

    modport slave (
        input  TBL_WE, TBL_IDX, TBL_NINST, TBL_ANS, TBL_LEN, START,
               NUM_INST, OUTPUT_PORT, HALT,
        output CYCLE, PASS_CNT, FAIL_CNT, FAIL_PULSE, FIRST_FAIL, FIRST_GOT,
               DONE, TIMEOUT, ALL_PASS
    );

endinterface

// File: rtl/riscv_test_checker_table.sv
// Check table: (instruction count, expected answer) pairs with one synchronous
// write port and one combinational read port. Contents have no reset.
module riscv_test_checker_table #(
    parameter int NUM_TEST = 32,
    parameter int DWIDTH   = 32,
    parameter int CWIDTH   = 32,
    parameter int IW       = 5
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IW-1:0]     widx_i,
    input  logic [CWIDTH-1:0] wninst_i,
    input  logic [DWIDTH-1:0] wans_i,
    input  logic [IW-1:0]     ridx_i,
    output logic [CWIDTH-1:0] rninst_o,
    output logic [DWIDTH-1:0] rans_o
);
    logic [CWIDTH+DWIDTH-1:0] mem_q [NUM_TEST];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[widx_i] <= {wninst_i, wans_i};
        end
    end

    assign {rninst_o, rans_o} = mem_q[ridx_i];

endmodule

// File: rtl/riscv_test_checker.sv
// Self-check monitor: walks the check table in order as the core retires
// instructions, counts passes/fails, and ends on HALT, stop-on-fail or timeout.
module riscv_test_checker
    import riscv_test_checker_pkg::*;
#(
    parameter int NUM_TEST     = 32,
    parameter int DWIDTH       = 32,
    parameter int CWIDTH       = 32,
    parameter int TIMEOUT_CYC  = 100000,
    parameter int STOP_ON_FAIL = 0
) (
    input logic                 CLK,
    input logic                 RST,
    riscv_test_checker_if.slave bus
);
    localparam int IW = chk_idx_w(NUM_TEST);
    localparam int LW = IW + 1;
    localparam logic [LW-1:0]     DEPTH    = LW'(NUM_TEST);
    localparam logic [CWIDTH-1:0] TMO_LAST = CWIDTH'(TIMEOUT_CYC - 1);
    localparam bit                STOP     = (STOP_ON_FAIL != 0);

    chk_state_e        state_q, state_d;
    logic [LW-1:0]     len_q, len_d, ptr_q, ptr_d;
    logic [LW-1:0]     pass_q, pass_d, fail_q, fail_d;
    logic [CWIDTH-1:0] cycle_q, cycle_d;
    logic              pulse_q, pulse_d, timeout_q, timeout_d;
    logic [IW-1:0]     first_idx_q, first_idx_d;
    logic [DWIDTH-1:0] first_got_q, first_got_d;

    logic [CWIDTH-1:0] e_ninst;
    logic [DWIDTH-1:0] e_ans;
    logic              active, hit, miss, chk_pass, chk_fail;

    riscv_test_checker_table #(
        .NUM_TEST (NUM_TEST),
        .DWIDTH   (DWIDTH),
        .CWIDTH   (CWIDTH),
        .IW       (IW)
    ) u_table (
        .clk_i    (CLK),
        .we_i     (bus.TBL_WE && (state_q == CHK_IDLE)),
        .widx_i   (bus.TBL_IDX),
        .wninst_i (bus.TBL_NINST),
        .wans_i   (bus.TBL_ANS),
        .ridx_i   (ptr_q[IW-1:0]),
        .rninst_o (e_ninst),
        .rans_o   (e_ans)
    );

    // A count already past the pending entry means the core skipped it: fail.
    assign active   = (state_q == CHK_RUN) && (ptr_q < len_q);
    assign hit      = active && (bus.NUM_INST == e_ninst);
    assign miss     = active && (bus.NUM_INST > e_ninst);
    assign chk_pass = hit && (bus.OUTPUT_PORT == e_ans);
    assign chk_fail = miss || (hit && !chk_pass);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= CHK_IDLE;
            len_q       <= '0;
            ptr_q       <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            cycle_q     <= '0;
            pulse_q     <= 1'b0;
            timeout_q   <= 1'b0;
            first_idx_q <= '0;
            first_got_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ptr_q       <= ptr_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            cycle_q     <= cycle_d;
            pulse_q     <= pulse_d;
            timeout_q   <= timeout_d;
            first_idx_q <= first_idx_d;
            first_got_q <= first_got_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        ptr_d       = ptr_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        cycle_d     = cycle_q;
        pulse_d     = 1'b0;
        timeout_d   = timeout_q;
        first_idx_d = first_idx_q;
        first_got_d = first_got_q;
        case (state_q)
            CHK_IDLE: begin
                if (bus.START) begin
                    state_d = CHK_RUN;
                    len_d   = (bus.TBL_LEN > DEPTH) ? DEPTH : bus.TBL_LEN;
                end
            end
            CHK_RUN: begin
                if (hit || miss) begin
                    ptr_d = ptr_q + LW'(1);
                end
                if (chk_pass && (pass_q < len_q)) begin
                    pass_d = pass_q + LW'(1);
                end
                if (chk_fail) begin
                    pulse_d = 1'b1;
                    if (fail_q < len_q) begin
                        fail_d = fail_q + LW'(1);
                    end
                    if (fail_q == '0) begin
                        first_idx_d = ptr_q[IW-1:0];
                        first_got_d = bus.OUTPUT_PORT;
                    end
                end
                // CYCLE only advances on edges that keep the run going.
                if (bus.HALT) begin
                    state_d = CHK_DONE;
                end else if (STOP && chk_fail) begin
                    state_d = CHK_DONE;
                end else if (cycle_q == TMO_LAST) begin
                    state_d   = CHK_DONE;
                    timeout_d = 1'b1;
                end else if (cycle_q != '1) begin
                    cycle_d = cycle_q + CWIDTH'(1);
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.CYCLE      = cycle_q;
    assign bus.PASS_CNT   = pass_q;
    assign bus.FAIL_CNT   = fail_q;
    assign bus.FAIL_PULSE = pulse_q;
    assign bus.FIRST_FAIL = first_idx_q;
    assign bus.FIRST_GOT  = first_got_q;
    assign bus.DONE       = (state_q == CHK_DONE);
    assign bus.TIMEOUT    = timeout_q;
    assign bus.ALL_PASS   = (state_q == CHK_DONE) && !timeout_q && (pass_q == len_q);

endmodule

// File: tb/tb_riscv_test_checker.sv
// Bench for riscv_test_checker: a continue-on-fail and a stop-on-fail instance
// share stimulus and are compared against an instruction-stream reference model.
module tb_riscv_test_checker;
    localparam int NT      = 8;
    localparam int DW      = 32;
    localparam int CW      = 16;
    localparam int TMO     = 50;
    localparam int SEQ_MAX = 64;
    localparam int IW      = $clog2(NT);
    localparam int LW      = IW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tbl_we = 1'b0;
    logic [IW-1:0] tbl_idx = '0;
    logic [CW-1:0] tbl_ninst = '0;
    logic [DW-1:0] tbl_ans = '0;
    logic [LW-1:0] tbl_len = '0;
    logic          start = 1'b0;
    logic [CW-1:0] num_inst = '0;
    logic [DW-1:0] out_port = '0;
    logic          halt = 1'b0;

    always #5 clk = ~clk;

    riscv_test_checker_if #(.NUM_TEST(NT), .DWIDTH(DW), .CWIDTH(CW)) if_c ();
    riscv_test_checker_if #(.NUM_TEST(NT), .DWIDTH(DW), .CWIDTH(CW)) if_s ();

    assign if_c.TBL_WE = tbl_we;      assign if_s.TBL_WE = tbl_we;
    assign if_c.TBL_IDX = tbl_idx;    assign if_s.TBL_IDX = tbl_idx;
    assign if_c.TBL_NINST = tbl_ninst; assign if_s.TBL_NINST = tbl_ninst;
    assign if_c.TBL_ANS = tbl_ans;    assign if_s.TBL_ANS = tbl_ans;
    assign if_c.TBL_LEN = tbl_len;    assign if_s.TBL_LEN = tbl_len;
    assign if_c.START = start;        assign if_s.START = start;
    assign if_c.NUM_INST = num_inst;  assign if_s.NUM_INST = num_inst;
    assign if_c.OUTPUT_PORT = out_port; assign if_s.OUTPUT_PORT = out_port;
    assign if_c.HALT = halt;          assign if_s.HALT = halt;

    riscv_test_checker #(.NUM_TEST(NT), .DWIDTH(DW), .CWIDTH(CW),
                         .TIMEOUT_CYC(TMO), .STOP_ON_FAIL(0))
        u_dut_cont (.CLK(clk), .RST(rst), .bus(if_c));
    riscv_test_checker #(.NUM_TEST(NT), .DWIDTH(DW), .CWIDTH(CW),
                         .TIMEOUT_CYC(TMO), .STOP_ON_FAIL(1))
        u_dut_stop (.CLK(clk), .RST(rst), .bus(if_s));

    // Index 0: continue-on-fail instance, index 1: stop-on-fail instance.
    logic [CW-1:0] obs_cycle [2];
    logic [LW-1:0] obs_pass [2];
    logic [LW-1:0] obs_fail [2];
    logic          obs_pulse [2];
    logic [IW-1:0] obs_first [2];
    logic [DW-1:0] obs_got [2];
    logic          obs_done [2];
    logic          obs_to [2];
    logic          obs_allp [2];
    assign obs_cycle[0] = if_c.CYCLE;       assign obs_cycle[1] = if_s.CYCLE;
    assign obs_pass[0]  = if_c.PASS_CNT;    assign obs_pass[1]  = if_s.PASS_CNT;
    assign obs_fail[0]  = if_c.FAIL_CNT;    assign obs_fail[1]  = if_s.FAIL_CNT;
    assign obs_pulse[0] = if_c.FAIL_PULSE;  assign obs_pulse[1] = if_s.FAIL_PULSE;
    assign obs_first[0] = if_c.FIRST_FAIL;  assign obs_first[1] = if_s.FIRST_FAIL;
    assign obs_got[0]   = if_c.FIRST_GOT;   assign obs_got[1]   = if_s.FIRST_GOT;
    assign obs_done[0]  = if_c.DONE;        assign obs_done[1]  = if_s.DONE;
    assign obs_to[0]    = if_c.TIMEOUT;     assign obs_to[1]    = if_s.TIMEOUT;
    assign obs_allp[0]  = if_c.ALL_PASS;    assign obs_allp[1]  = if_s.ALL_PASS;

    int n_checks = 0;
    int n_fail   = 0;

    int            tab_n [NT];
    logic [DW-1:0] tab_a [NT];
    int            tab_len;
    int            seq_n [SEQ_MAX];
    logic [DW-1:0] seq_o [SEQ_MAX];
    bit            seq_h [SEQ_MAX];
    int            seq_len;

    int            e_pass [2];
    int            e_fail [2];
    int            e_first [2];
    int            e_cyc [2];
    int            e_end [2];
    logic [DW-1:0] e_got [2];
    bit            e_to [2];
    bit            e_pulse [2][SEQ_MAX];

    // Reference: walk the retirement stream against the ordered table.
    task automatic model(input int k);
        int ptr;
        bit f;
        ptr = 0;
        e_pass[k] = 0; e_fail[k] = 0; e_first[k] = 0; e_got[k] = '0;
        e_to[k] = 0; e_cyc[k] = 0; e_end[k] = -1;
        for (int c = 0; c < SEQ_MAX; c++) e_pulse[k][c] = 0;
        for (int c = 0; c < seq_len; c++) begin
            f = 0;
            if (ptr < tab_len) begin
                if (seq_n[c] == tab_n[ptr]) begin
                    if (seq_o[c] == tab_a[ptr]) e_pass[k]++;
                    else f = 1;
                    ptr++;
                end else if (seq_n[c] > tab_n[ptr]) begin
                    f = 1;
                    ptr++;
                end
            end
            if (f) begin
                if (e_fail[k] == 0) begin
                    e_first[k] = ptr - 1;
                    e_got[k]   = seq_o[c];
                end
                e_fail[k]++;
                e_pulse[k][c] = 1;
            end
            e_cyc[k] = c;
            if (seq_h[c] || (k == 1 && f)) begin
                e_end[k] = c;
                break;
            end
            if (c == TMO - 1) begin
                e_to[k]  = 1;
                e_end[k] = c;
                break;
            end
            e_cyc[k] = c + 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; tbl_we = 1'b0; halt = 1'b0;
        num_inst = '0; out_port = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < tab_len; i++) begin
            @(negedge clk);
            tbl_we = 1'b1; tbl_idx = IW'(i);
            tbl_ninst = CW'(tab_n[i]); tbl_ans = tab_a[i];
        end
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    // Starts a run, checks every RUN cycle, then (unless aborted) checks the
    // frozen final results after a few junk cycles with START/TBL_WE active.
    task automatic run_seq(input int abort_at);
        int steps;
        bit exp_done, exp_allp;
        model(0);
        model(1);
        steps = (e_end[0] >= 0) ? e_end[0] + 1 : seq_len;
        if (abort_at >= 0 && abort_at < steps) steps = abort_at;
        @(negedge clk);
        start = 1'b1; tbl_len = LW'(tab_len);
        @(posedge clk);
        for (int c = 0; c < steps; c++) begin
            @(negedge clk);
            start = 1'b0;
            num_inst = CW'(seq_n[c]); out_port = seq_o[c]; halt = seq_h[c];
            tbl_we = 1'($urandom_range(0, 1)); tbl_idx = IW'($urandom_range(0, NT - 1));
            tbl_ninst = CW'($urandom); tbl_ans = $urandom;
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                exp_done = (e_end[k] >= 0) && (c >= e_end[k]);
                n_checks++;
                if (obs_pulse[k] !== e_pulse[k][c]) begin
                    n_fail++;
                    $display("FAIL pulse dut%0d step %0d: got %0b expected %0b", k, c, obs_pulse[k], e_pulse[k][c]);
                end
                n_checks++;
                if (obs_done[k] !== exp_done) begin
                    n_fail++;
                    $display("FAIL done dut%0d step %0d: got %0b expected %0b", k, c, obs_done[k], exp_done);
                end
            end
        end
        if (abort_at >= 0) return;
        @(negedge clk);
        tbl_we = 1'b0; halt = 1'b0;
        if (e_end[0] < 0) return;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; tbl_we = 1'b1; halt = 1'($urandom_range(0, 1));
            num_inst = CW'($urandom); out_port = $urandom;
        end
        @(negedge clk);
        start = 1'b0; tbl_we = 1'b0; halt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            exp_allp = !e_to[k] && (e_pass[k] == tab_len);
            n_checks++;
            if (obs_done[k] !== 1'b1) begin
                n_fail++; $display("FAIL final_done dut%0d: got %0b expected 1", k, obs_done[k]);
            end
            n_checks++;
            if (obs_to[k] !== e_to[k]) begin
                n_fail++; $display("FAIL final_timeout dut%0d: got %0b expected %0b", k, obs_to[k], e_to[k]);
            end
            n_checks++;
            if (obs_pass[k] !== LW'(e_pass[k])) begin
                n_fail++; $display("FAIL final_pass dut%0d: got %0d expected %0d", k, obs_pass[k], e_pass[k]);
            end
            n_checks++;
            if (obs_fail[k] !== LW'(e_fail[k])) begin
                n_fail++; $display("FAIL final_failcnt dut%0d: got %0d expected %0d", k, obs_fail[k], e_fail[k]);
            end
            n_checks++;
            if (obs_first[k] !== IW'(e_first[k])) begin
                n_fail++; $display("FAIL final_first dut%0d: got %0d expected %0d", k, obs_first[k], e_first[k]);
            end
            n_checks++;
            if (obs_got[k] !== e_got[k]) begin
                n_fail++; $display("FAIL final_got dut%0d: got %0h expected %0h", k, obs_got[k], e_got[k]);
            end
            n_checks++;
            if (obs_cycle[k] !== CW'(e_cyc[k])) begin
                n_fail++; $display("FAIL final_cycle dut%0d: got %0d expected %0d", k, obs_cycle[k], e_cyc[k]);
            end
            n_checks++;
            if (obs_allp[k] !== exp_allp) begin
                n_fail++; $display("FAIL final_allpass dut%0d: got %0b expected %0b", k, obs_allp[k], exp_allp);
            end
            n_checks++;
            if (obs_pulse[k] !== 1'b0) begin
                n_fail++; $display("FAIL final_pulse dut%0d: got %0b expected 0", k, obs_pulse[k]);
            end
        end
    endtask

    task automatic set_seq(input int idx, input int n, input logic [DW-1:0] o, input bit h);
        seq_n[idx] = n; seq_o[idx] = o; seq_h[idx] = h;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_cycle[k] !== '0 || obs_pass[k] !== '0 || obs_fail[k] !== '0) begin
                n_fail++; $display("FAIL reset_counts dut%0d: got cyc=%0d pass=%0d fail=%0d expected 0", k, obs_cycle[k], obs_pass[k], obs_fail[k]);
            end
            n_checks++;
            if (obs_pulse[k] !== 1'b0 || obs_done[k] !== 1'b0 || obs_to[k] !== 1'b0 || obs_allp[k] !== 1'b0) begin
                n_fail++; $display("FAIL reset_flags dut%0d: got pulse=%0b done=%0b to=%0b allp=%0b expected 0", k, obs_pulse[k], obs_done[k], obs_to[k], obs_allp[k]);
            end
            n_checks++;
            if (obs_first[k] !== '0 || obs_got[k] !== '0) begin
                n_fail++; $display("FAIL reset_capture dut%0d: got first=%0d got=%0h expected 0", k, obs_first[k], obs_got[k]);
            end
        end
        $display("test_reset done");
    endtask

    task automatic load_basic3();
        tab_len = 3;
        tab_n[0] = 1; tab_a[0] = 32'd5;
        tab_n[1] = 2; tab_a[1] = 32'd0;
        tab_n[2] = 3; tab_a[2] = 32'd1;
        seq_len = 4;
        set_seq(0, 1, 32'd5, 0); set_seq(1, 2, 32'd0, 0);
        set_seq(2, 3, 32'd1, 0); set_seq(3, 4, 32'd9, 1);
    endtask

    task automatic test_all_pass();
        do_reset();
        load_basic3();
        load_table();
        run_seq(-1);
        n_checks++;
        if (obs_pass[0] !== LW'(3) || obs_fail[0] !== '0) begin
            n_fail++; $display("FAIL all_pass_counts: got pass=%0d fail=%0d expected 3/0", obs_pass[0], obs_fail[0]);
        end
        n_checks++;
        if (obs_allp[0] !== 1'b1 || obs_to[0] !== 1'b0) begin
            n_fail++; $display("FAIL all_pass_flags: got allp=%0b to=%0b expected 1/0", obs_allp[0], obs_to[0]);
        end
        $display("test_all_pass done: pass=%0d fail=%0d", obs_pass[0], obs_fail[0]);
    endtask

    task automatic test_mismatch();
        do_reset();
        tab_len = 3;
        tab_n[0] = 1; tab_a[0] = 32'h0a;
        tab_n[1] = 2; tab_a[1] = 32'h0f;
        tab_n[2] = 3; tab_a[2] = 32'h11;
        seq_len = 4;
        set_seq(0, 1, 32'h0a, 0); set_seq(1, 2, 32'h0e, 0);
        set_seq(2, 3, 32'h11, 0); set_seq(3, 4, 32'h00, 1);
        load_table();
        run_seq(-1);
        n_checks++;
        if (obs_first[0] !== IW'(1) || obs_got[0] !== 32'h0e) begin
            n_fail++; $display("FAIL mismatch_capture: got first=%0d got=%0h expected 1/e", obs_first[0], obs_got[0]);
        end
        n_checks++;
        if (obs_pass[0] !== LW'(2) || obs_fail[0] !== LW'(1) || obs_allp[0] !== 1'b0) begin
            n_fail++; $display("FAIL mismatch_cont: got pass=%0d fail=%0d allp=%0b expected 2/1/0", obs_pass[0], obs_fail[0], obs_allp[0]);
        end
        n_checks++;
        if (obs_pass[1] !== LW'(1) || obs_cycle[1] !== CW'(1) || obs_done[1] !== 1'b1) begin
            n_fail++; $display("FAIL mismatch_stop: got pass=%0d cyc=%0d done=%0b expected 1/1/1", obs_pass[1], obs_cycle[1], obs_done[1]);
        end
        $display("test_mismatch done: first=%0d got=%0h", obs_first[0], obs_got[0]);
    endtask

    task automatic test_missed();
        do_reset();
        tab_len = 3;
        tab_n[0] = 1; tab_a[0] = 32'd3;
        tab_n[1] = 2; tab_a[1] = 32'd4;
        tab_n[2] = 3; tab_a[2] = 32'd5;
        seq_len = 4;
        set_seq(0, 1, 32'd3, 0); set_seq(1, 3, 32'd5, 0);
        set_seq(2, 3, 32'd5, 0); set_seq(3, 4, 32'd0, 1);
        load_table();
        run_seq(-1);
        n_checks++;
        if (obs_pass[0] !== LW'(2) || obs_fail[0] !== LW'(1) || obs_first[0] !== IW'(1) || obs_got[0] !== 32'd5) begin
            n_fail++; $display("FAIL missed: got pass=%0d fail=%0d first=%0d got=%0h expected 2/1/1/5", obs_pass[0], obs_fail[0], obs_first[0], obs_got[0]);
        end
        $display("test_missed done: pass=%0d fail=%0d", obs_pass[0], obs_fail[0]);
    endtask

    task automatic test_timeout();
        do_reset();
        tab_len = 2;
        tab_n[0] = 100; tab_a[0] = 32'd1;
        tab_n[1] = 200; tab_a[1] = 32'd2;
        seq_len = TMO;
        for (int c = 0; c < TMO; c++) set_seq(c, c / 3, 32'($urandom), 0);
        load_table();
        run_seq(-1);
        n_checks++;
        if (obs_to[0] !== 1'b1 || obs_done[0] !== 1'b1 || obs_cycle[0] !== CW'(TMO - 1) || obs_allp[0] !== 1'b0) begin
            n_fail++; $display("FAIL timeout: got to=%0b done=%0b cyc=%0d allp=%0b expected 1/1/%0d/0", obs_to[0], obs_done[0], obs_cycle[0], obs_allp[0], TMO - 1);
        end
        $display("test_timeout done: cycle=%0d", obs_cycle[0]);
    endtask

    task automatic test_stop_halt();
        do_reset();
        tab_len = 2;
        tab_n[0] = 1; tab_a[0] = 32'd5;
        tab_n[1] = 2; tab_a[1] = 32'd6;
        seq_len = 2;
        set_seq(0, 1, 32'd5, 0); set_seq(1, 2, 32'd7, 1);
        load_table();
        run_seq(-1);
        n_checks++;
        if (obs_fail[1] !== LW'(1) || obs_done[1] !== 1'b1 || obs_to[1] !== 1'b0) begin
            n_fail++; $display("FAIL stop_halt: got fail=%0d done=%0b to=%0b expected 1/1/0", obs_fail[1], obs_done[1], obs_to[1]);
        end
        $display("test_stop_halt done: fail=%0d", obs_fail[1]);
    endtask

    task automatic test_len_zero();
        do_reset();
        tab_len = 0;
        seq_len = 4;
        for (int c = 0; c < 4; c++) set_seq(c, c + 1, 32'($urandom), c == 3);
        run_seq(-1);
        n_checks++;
        if (obs_allp[0] !== 1'b1 || obs_allp[1] !== 1'b1 || obs_fail[0] !== '0) begin
            n_fail++; $display("FAIL len_zero: got allp=%0b/%0b fail=%0d expected 1/1/0", obs_allp[0], obs_allp[1], obs_fail[0]);
        end
        $display("test_len_zero done");
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        load_basic3();
        load_table();
        run_seq(2);
        n_checks++;
        if (obs_pass[0] !== LW'(2) || obs_cycle[0] !== CW'(2) || obs_done[0] !== 1'b0) begin
            n_fail++; $display("FAIL midrun_pre: got pass=%0d cyc=%0d done=%0b expected 2/2/0", obs_pass[0], obs_cycle[0], obs_done[0]);
        end
        do_reset();
        n_checks++;
        if (obs_pass[0] !== '0 || obs_cycle[0] !== '0 || obs_done[0] !== 1'b0) begin
            n_fail++; $display("FAIL midrun_cleared: got pass=%0d cyc=%0d done=%0b expected 0/0/0", obs_pass[0], obs_cycle[0], obs_done[0]);
        end
        run_seq(-1);
        n_checks++;
        if (obs_pass[0] !== LW'(3) || obs_allp[0] !== 1'b1) begin
            n_fail++; $display("FAIL midrun_rerun: got pass=%0d allp=%0b expected 3/1", obs_pass[0], obs_allp[0]);
        end
        $display("test_reset_mid_run done: pass=%0d", obs_pass[0]);
    endtask

    task automatic test_random();
        int n;
        int cur;
        int halt_at;
        logic [DW-1:0] o;
        for (int it = 0; it < 25; it++) begin
            do_reset();
            tab_len = $urandom_range(0, NT);
            n = 0;
            for (int i = 0; i < tab_len; i++) begin
                n += $urandom_range(1, 3);
                tab_n[i] = n;
                tab_a[i] = DW'($urandom_range(0, 3));
            end
            halt_at = ($urandom_range(0, 3) != 0) ? $urandom_range(2, 45) : -1;
            seq_len = TMO;
            cur = 0;
            for (int c = 0; c < TMO; c++) begin
                cur += $urandom_range(0, 2);
                o = DW'($urandom_range(0, 3));
                for (int i = 0; i < tab_len; i++)
                    if (tab_n[i] == cur && $urandom_range(0, 4) != 0) o = tab_a[i];
                set_seq(c, cur, o, c == halt_at);
            end
            load_table();
            run_seq(-1);
            $display("test_random iter %0d: len=%0d halt_at=%0d pass=%0d fail=%0d", it, tab_len, halt_at, obs_pass[0], obs_fail[0]);
        end
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_mismatch();
        test_missed();
        test_timeout();
        test_stop_halt();
        test_len_zero();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
